// File: rtl/mult_processor412.sv
// Memory-mapped multiply coprocessor: 2^AW x DW data memory with a host port and a
// shift-add sequencer that computes dmem[A] * dmem[B] into dmem[P], dmem[P+1].
//
// state | meaning
// IDLE  | host port live; waits for start
// LDA   | fetch operand A, clear product accumulator
// LDB   | fetch operand B, clear iteration count
// MUL   | one shift-add step per cycle, DW cycles
// STL   | store product low word
// STH   | store product high word, raise ready

module mult_processor412 #(
  parameter int DW    = 32,
  parameter int AW    = 9,
  parameter int A_ADR = 0,
  parameter int B_ADR = 1,
  parameter int P_ADR = 2
) (
  input  logic          ck,
  input  logic          rb,
  input  logic          start,
  output logic          ready,
  input  logic          dcen,
  input  logic          dwen,
  input  logic [AW-1:0] dadr,
  input  logic [DW-1:0] dinp,
  output logic [DW-1:0] dout
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(DW);
  localparam logic [AW-1:0] A_LOC  = AW'(A_ADR);
  localparam logic [AW-1:0] B_LOC  = AW'(B_ADR);
  localparam logic [AW-1:0] PL_LOC = AW'(P_ADR);
  localparam logic [AW-1:0] PH_LOC = AW'(P_ADR + 1);
  localparam logic [CW-1:0] LAST   = CW'(DW - 1);

  typedef enum logic [2:0] {IDLE, LDA, LDB, MUL, STL, STH} state_t;

  state_t          state;
  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   a;
  logic [DW-1:0]   b;
  logic [2*DW-1:0] p;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   addend;
  logic [DW:0]     sum;
  logic            host_wr;
  logic            host_rd;

  assign host_wr = (state == IDLE) && dcen && dwen;
  assign host_rd = (state == IDLE) && dcen && !dwen;

  // Right-shifting accumulator: add into the high half, then shift the whole
  // product right one bit; after DW steps p holds the full product.
  assign addend = b[0] ? a : '0;
  assign sum    = {1'b0, p[2*DW-1:DW]} + {1'b0, addend};

  // Single write port; reset blocks writes so an aborted run leaves results intact.
  always_ff @(posedge ck) begin
    if (rb) begin
      if (host_wr)
        mem[dadr] <= dinp;
      else if (state == STL)
        mem[PL_LOC] <= p[DW-1:0];
      else if (state == STH)
        mem[PH_LOC] <= p[2*DW-1:DW];
    end
  end

  always_ff @(posedge ck) begin
    if (!rb) begin
      state <= IDLE;
      ready <= 1'b0;
      dout  <= '0;
      a     <= '0;
      b     <= '0;
      p     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (host_rd)
            dout <= mem[dadr];
          if (start) begin
            ready <= 1'b0;
            state <= LDA;
          end
        end
        LDA: begin
          a     <= mem[A_LOC];
          p     <= '0;
          state <= LDB;
        end
        LDB: begin
          b     <= mem[B_LOC];
          cnt   <= '0;
          state <= MUL;
        end
        MUL: begin
          p   <= {sum, p[DW-1:1]};
          b   <= b >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= STL;
        end
        STL: state <= STH;
        STH: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_processor412.sv
// Self-checking bench for mult_processor412: random operands checked against a
// plain-arithmetic memory model, plus latency, busy-lockout, reset and wrap cases.

module tb_mult_processor412;

  logic        ck = 1'b0;
  logic        rb;
  logic        start;
  logic        ready;
  logic        dcen;
  logic        dwen;
  logic [8:0]  dadr;
  logic [31:0] dinp;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [512];

  mult_processor412 dut (
    .ck(ck), .rb(rb), .start(start), .ready(ready),
    .dcen(dcen), .dwen(dwen), .dadr(dadr), .dinp(dinp), .dout(dout)
  );

  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic host_write(input logic [8:0] addr, input logic [31:0] data);
    dadr = addr; dinp = data; dcen = 1'b1; dwen = 1'b1;
    tick();
    dcen = 1'b0; dwen = 1'b0;
    ref_mem[addr] = data;
  endtask

  task automatic host_read(input logic [8:0] addr, output logic [31:0] data);
    dadr = addr; dcen = 1'b1; dwen = 1'b0;
    tick();
    data = dout;
    dcen = 1'b0;
  endtask

  // Pulse start, return ready right after the start edge and the edge count to ready.
  task automatic run_mult(output logic r0, output int lat);
    logic [63:0] prod;
    prod = {32'b0, ref_mem[0]} * {32'b0, ref_mem[1]};
    start = 1'b1;
    tick();
    start = 1'b0;
    r0  = ready;
    lat = -1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (ready) begin lat = k; break; end
    end
    if (lat > 0) begin
      ref_mem[2] = prod[31:0];
      ref_mem[3] = prod[63:32];
    end
  endtask

  task automatic test_reset();
    rb = 1'b0; start = 1'b0; dcen = 1'b0; dwen = 1'b0; dadr = '0; dinp = '0;
    tick(); tick();
    rb = 1'b1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", ready); end
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
  endtask

  task automatic test_spec_vector();
    logic r0; int lat; logic [31:0] d;
    host_write(9'd0, 32'h1F142570);
    host_write(9'd1, 32'h001200C2);
    run_mult(r0, lat);
    checks++;
    if (lat != 36) begin errors++; $display("FAIL spec_latency got %0d exp 36", lat); end
    host_read(9'd2, d);
    checks++;
    if (d !== 32'h2F245EE0) begin errors++; $display("FAIL spec_lo got %h exp 2f245ee0", d); end
    host_read(9'd3, d);
    checks++;
    if (d !== 32'h00022F82) begin errors++; $display("FAIL spec_hi got %h exp 00022f82", d); end
  endtask

  task automatic test_products();
    logic r0; int lat; logic [31:0] d;
    logic [31:0] opa [10];
    logic [31:0] opb [10];
    opa[0] = 32'hFFFFFFFF; opb[0] = 32'hFFFFFFFF;
    opa[1] = 32'h0;        opb[1] = 32'h12345678;
    opa[2] = 32'h87654321; opb[2] = 32'h0;
    opa[3] = 32'h1;        opb[3] = 32'h80000000;
    for (int i = 4; i < 10; i++) begin
      opa[i] = $urandom; opb[i] = $urandom;
    end
    for (int i = 0; i < 10; i++) begin
      host_write(9'd0, opa[i]);
      host_write(9'd1, opb[i]);
      run_mult(r0, lat);
      checks++;
      if (lat != 36) begin errors++; $display("FAIL prod_latency[%0d] got %0d exp 36", i, lat); end
      host_read(9'd2, d);
      checks++;
      if (d !== ref_mem[2]) begin errors++; $display("FAIL prod_lo[%0d] got %h exp %h", i, d, ref_mem[2]); end
      host_read(9'd3, d);
      checks++;
      if (d !== ref_mem[3]) begin errors++; $display("FAIL prod_hi[%0d] got %h exp %h", i, d, ref_mem[3]); end
      if (i == 0) begin
        checks++;
        if (d !== 32'hFFFFFFFE) begin errors++; $display("FAIL max_hi got %h exp fffffffe", d); end
      end
    end
  endtask

  task automatic test_busy();
    logic [31:0] d, held;
    logic [63:0] prod;
    int e, rises;
    host_write(9'd0, $urandom | 32'h1);
    host_write(9'd1, $urandom | 32'h1);
    host_read(9'd1, held);
    prod = {32'b0, ref_mem[0]} * {32'b0, ref_mem[1]};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    // write and re-start while in MUL: both must be ignored
    dadr = 9'd0; dinp = ~ref_mem[0]; dcen = 1'b1; dwen = 1'b1; start = 1'b1;
    tick();
    dwen = 1'b0; start = 1'b0;
    tick();
    dcen = 1'b0;
    checks++;
    if (dout !== held) begin errors++; $display("FAIL busy_dout_hold got %h exp %h", dout, held); end
    e = 12;
    while (!ready && e < 80) begin tick(); e++; end
    checks++;
    if (e != 36) begin errors++; $display("FAIL busy_latency got %0d exp 36", e); end
    rises = 0;
    for (int k = 0; k < 40; k++) begin
      if (!ready) rises = -100;
      tick();
    end
    checks++;
    if (rises != 0) begin errors++; $display("FAIL busy_ready_once got dropped exp held high"); end
    ref_mem[2] = prod[31:0];
    ref_mem[3] = prod[63:32];
    host_read(9'd0, d);
    checks++;
    if (d !== ref_mem[0]) begin errors++; $display("FAIL busy_opa got %h exp %h", d, ref_mem[0]); end
    host_read(9'd2, d);
    checks++;
    if (d !== ref_mem[2]) begin errors++; $display("FAIL busy_lo got %h exp %h", d, ref_mem[2]); end
    host_read(9'd3, d);
    checks++;
    if (d !== ref_mem[3]) begin errors++; $display("FAIL busy_hi got %h exp %h", d, ref_mem[3]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic r0; int lat;
    host_write(9'd0, $urandom | 32'h100);
    host_write(9'd1, $urandom | 32'h100);
    host_read(9'd1, d);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 15; k++) tick();
    rb = 1'b0;
    tick();
    rb = 1'b1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %0b exp 0", ready); end
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL rstmid_dout got %h exp 0", dout); end
    for (int i = 0; i < 4; i++) begin
      host_read(9'(i), d);
      checks++;
      if (d !== ref_mem[i]) begin errors++; $display("FAIL rstmid_mem[%0d] got %h exp %h", i, d, ref_mem[i]); end
    end
    run_mult(r0, lat);
    checks++;
    if (lat != 36) begin errors++; $display("FAIL rstmid_rerun_latency got %0d exp 36", lat); end
    host_read(9'd2, d);
    checks++;
    if (d !== ref_mem[2]) begin errors++; $display("FAIL rstmid_rerun_lo got %h exp %h", d, ref_mem[2]); end
    host_read(9'd3, d);
    checks++;
    if (d !== ref_mem[3]) begin errors++; $display("FAIL rstmid_rerun_hi got %h exp %h", d, ref_mem[3]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic r0; int lat;
    host_write(9'd0, 32'd3);
    host_write(9'd1, 32'd5);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_before got %0b exp 1", ready); end
    run_mult(r0, lat);
    checks++;
    if (r0 !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop got %0b exp 0", r0); end
    checks++;
    if (lat != 36) begin errors++; $display("FAIL b2b_latency got %0d exp 36", lat); end
    host_read(9'd2, d);
    checks++;
    if (d !== 32'd15) begin errors++; $display("FAIL b2b_lo got %h exp 0000000f", d); end
    host_read(9'd3, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL b2b_hi got %h exp 0", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    host_write(9'd511, 32'hDEADBEEF);
    host_read(9'd511, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL top_addr got %h exp deadbeef", d); end
    dcen = 1'b0; dwen = 1'b0; dadr = 9'd2; dinp = 32'h5A5A5A5A;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL dcen_hold got %h exp deadbeef", dout); end
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_products();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_processor412.md
Name: mult_processor412

Overview:
- Small self-contained compute block: a 512x32 data memory with a host access port, plus a multi-cycle sequencer.
- On `start`, the sequencer multiplies dmem[0] by dmem[1] as unsigned 32x32 operands and stores the 64-bit product to dmem[2] (low word) and dmem[3] (high word), then raises `ready`.
- Used as a memory-mapped multiply coprocessor: the host loads operands, pulses `start`, waits for `ready`, then reads the result back.

Parameters:
- DW, 32, data/operand word width.
- AW, 9, data memory address width (512 words).
- A_ADR, 0, address of operand A.
- B_ADR, 1, address of operand B.
- P_ADR, 2, address of product low word; high word at P_ADR+1.

Ports:
- ck  input  1  clock; all state updates on rising edge.
- rb  input  1  reset, synchronous, active-low.
- start  input  1  begin a multiply; sampled only in IDLE.
- ready  output  1  high = last multiply complete and result stored in dmem.
- dcen  input  1  host memory access enable.
- dwen  input  1  host write enable (1 = write, 0 = read), qualified by dcen.
- dadr  input  AW  host word address.
- dinp  input  DW  host write data.
- dout  output  DW  host read data, registered.

Behaviour:
- Reset (rb=0 at a rising edge):
  - state=IDLE, ready=0, dout=0; internal A, B and accumulator registers cleared.
  - dmem contents are NOT cleared.
  - Reset mid-operation aborts the multiply; dmem[P_ADR..P_ADR+1] keep their previous values.
- Host port, honoured only while state=IDLE:
  - dcen=1, dwen=1: dmem[dadr] <= dinp.
  - dcen=1, dwen=0: dout <= dmem[dadr], valid the cycle after the address is sampled.
  - dcen=0: dout holds its value.
  - While busy (state≠IDLE), host reads and writes are ignored and dout holds.
- Internal memory reads are combinational from the array; internal writes happen at the rising edge.
- States: IDLE, LDA, LDB, MUL, STL, STH.
  - IDLE: start=1 -> LDA, ready<=0. A host write sampled on the same edge as start is applied and is visible to LDA.
  - LDA: A <= dmem[A_ADR]; product accumulator P(64b) <= 0 -> LDB.
  - LDB: B <= dmem[B_ADR]; iteration count <= 0 -> MUL.
  - MUL: one shift-add step per cycle, for exactly 32 cycles -> STL.
    - If B[0]=1: P <= P + (A << i) (equivalently a right-shifting accumulator form).
    - B <= B >> 1.
  - STL: dmem[P_ADR] <= P[31:0] -> STH.
  - STH: dmem[P_ADR+1] <= P[63:32]; ready <= 1 -> IDLE.
- Latency: with the start-sampling edge counted as edge 0, ready rises at edge 36, and the result is readable by the host from then on.
- ready stays 1 until the next accepted start; start while busy is ignored.
- Arithmetic:
  - Unsigned, full 64-bit product; no overflow is possible.
  - A 0 operand yields 0; 0xFFFFFFFF x 0xFFFFFFFF = 0xFFFFFFFE_00000001.
- Address wrap: dadr is AW bits; no out-of-range condition exists.

Test Plan:
1. Reset, write dmem[0]=0x1F142570 and dmem[1]=0x001200C2, pulse start for 1 cycle -> ready rises 36 edges after the start sample; reads of dmem[2]=0x2F245EE0 and dmem[3]=0x00022F82, each dout valid one cycle after the address.
2. Operands 0xFFFFFFFF and 0xFFFFFFFF -> dmem[2]=0x00000001, dmem[3]=0xFFFFFFFE; operands 0 and 0x12345678 -> both result words 0.
3. Host write to dmem[0] during MUL, and start re-pulsed while busy -> write dropped and operand unchanged; result equals the original product; ready rises exactly once.
4. Assert rb=0 mid-MUL -> next cycle ready=0, dout=0, state IDLE; dmem[0..3] retain pre-start contents; a new start then completes normally.
5. Back-to-back runs: after ready, load new operands 3 and 5 and start -> ready drops at the start edge; dmem[2]=15, dmem[3]=0.
6. Write 0xDEADBEEF to dmem[511], then read it -> dout=0xDEADBEEF; dcen=0 afterwards -> dout holds.
